ahb_slave_interface: RTL
========================

# ahb_slave_interface

Responder end of the AHB bus: a single-port AHB slave backed by a small word-addressed register file. It samples address-phase signals from the master interface (routed through the decoder/mux), inserts a programmable number of wait states, and completes transfers with OKAY or a two-cycle ERROR response. It is the counterpart to the master interfaces: it drives hready, hresp and hrdata back to them.

## Interface
- MEM_DEPTH, 16, number of 32-bit words; power of 2, at least 2
- WAIT_STATES, 1, hready-low cycles inserted before each valid OKAY data phase; 0 to 15
- hclk  in  1  bus clock; all logic on the rising edge
- hresetn  in  1  synchronous, active-low reset
- hsel  in  1  slave select from the decoder
- haddr  in  32  byte address (address phase)
- hwrite  in  1  1 = write, 0 = read (address phase)
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwdata  in  32  write data (data phase)
- hrdata  out  32  read data, valid while hready=1 in a read data phase
- hready  out  1  1 = current data phase completes this cycle
- hresp  out  2  00 OKAY, 01 ERROR (10/11 never driven)

## Operation
- IDX_W = log2(MEM_DEPTH). Word index = haddr[2+IDX_W-1:2].
- Address is legal when haddr[1:0] = 0 and haddr[31:2+IDX_W] = 0.
- A transfer is accepted on a rising edge when hready=1, hsel=1 and htrans is NONSEQ or SEQ. On acceptance, capture the index, hwrite and legality.
- IDLE and BUSY transfers, and cycles with hsel=0, are not accepted and get a zero-wait OKAY.
- States:
  - ST_IDLE: hready=1, hresp=OKAY. Accept legal, WAIT_STATES>0 -> ST_WAIT with counter = WAIT_STATES-1. Accept legal, WAIT_STATES=0 -> ST_RESP. Accept illegal -> ST_ERR1. Otherwise stay.
  - ST_WAIT: hready=0, hresp=OKAY. Counter decrements. At 0 -> ST_RESP.
  - ST_RESP: hready=1, hresp=OKAY.
    - Write: mem[captured idx] <= hwdata at the closing edge.
    - Read: hrdata holds mem[captured idx], loaded at the edge entering ST_RESP.
    - A new transfer may be accepted at the same edge, with the same transitions as ST_IDLE. Otherwise -> ST_IDLE.
  - ST_ERR1: hready=0, hresp=ERROR. Next state is ST_ERR2.
  - ST_ERR2: hready=1, hresp=ERROR. No memory access. Accepts a new transfer like ST_IDLE.
- Error transfers never modify memory. hrdata is unchanged by them.
- Forwarding: if a read is accepted with WAIT_STATES=0 at the same edge a write commits to the same index, hrdata <= hwdata (the new data).
- hrdata changes only when entering ST_RESP for a read. It holds its value otherwise.

## Timing
- Reset (hresetn=0 at an edge): state ST_IDLE, hready=1, hresp=00, hrdata=0, wait counter 0, all memory words 0.
- Reset wins over any in-flight transfer. A write in ST_WAIT or ST_RESP at the reset edge is discarded.
- Outputs are registered: state-decoded from the flops, or hrdata flops. No input-to-output combinational path.
- OKAY transfer accepted at edge E: hready=0 for cycles E..E+WAIT_STATES-1, then hready=1 for one cycle. Total data phase = WAIT_STATES+1 cycles.
- ERROR transfer: always 2 cycles (hready 0 then 1, hresp=01 in both), regardless of WAIT_STATES.
- Back-to-back sustained rate: one transfer per WAIT_STATES+1 cycles. With WAIT_STATES=0 this is one per cycle.
- hwdata is sampled only at the edge closing ST_RESP. It is ignored in ST_WAIT.
- htrans/haddr changes while hready=0 are ignored. The master must hold them, but the slave does not check.

## Test plan
- Reset: drive hresetn=0 for 2 cycles -> hready=1, hresp=00, hrdata=0. Then read index 5 -> returns 0x00000000.
- Write then read, WAIT_STATES=1: NONSEQ write 0x14 with hwdata=0xDEADBEEF -> hready=0 for 1 cycle, then 1 with OKAY. NONSEQ read 0x14 -> hrdata=0xDEADBEEF in the hready=1 cycle.
- Back-to-back, WAIT_STATES=0: write 0x08=0x12345678 immediately followed by a read of 0x08 -> read returns 0x12345678 via forwarding. hready stays 1 throughout.
- Errors:
  - Address 0x40 (MEM_DEPTH=16) -> hready 0/1 with hresp=01 both cycles, memory unchanged.
  - Address 0x02 (unaligned) -> same ERROR response.
  - A legal read right after ST_ERR2 -> completes OKAY.
- IDLE/BUSY/hsel=0:
  - htrans=01 with hsel=1 -> no access, hready=1, OKAY.
  - Write with hsel=0 -> memory unchanged; a later read of that word returns its old value.
- Reset mid-transfer: WAIT_STATES=3 write to 0x0C, hresetn=0 during ST_WAIT -> ST_IDLE and hready=1 next cycle. Read of 0x0C returns 0.

Source files
------------

// File: rtl/ahb_slave_interface.sv
// AHB slave backed by a word-addressed register file.
// Programmable wait states; two-cycle ERROR for illegal addresses.
module ahb_slave_interface #(
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_write;
  logic [31:0]        r_hrdata;
  logic [31:0]        r_mem [MEM_DEPTH];

  logic               w_ready;
  logic               w_accept;
  logic               w_legal;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ld_idx;
  logic               w_ld_wr;
  logic               w_commit;
  logic               w_rd_load;
  logic [31:0]        w_rd_val;
  logic               w_unused;

  assign w_unused = htrans[0];

  assign w_ready  = (r_state == ST_IDLE) ||
                    (r_state == ST_RESP) ||
                    (r_state == ST_ERR2);
  assign w_accept = w_ready && hsel && htrans[1];
  assign w_idx    = haddr[2+IDX_W-1:2];
  assign w_legal  = (haddr[1:0] == 2'b00) &&
                    (haddr[31:2+IDX_W] == '0);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_RESP;
        else               w_cnt_nxt = r_cnt - 4'd1;
      end
      ST_ERR1: w_next = ST_ERR2;
      default: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next    = ST_WAIT;
            w_cnt_nxt = 4'(WAIT_STATES - 1);
          end else begin
            w_next = ST_RESP;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
    endcase
  end

  // RESP is entered either from WAIT (captured transfer) or directly on accept
  assign w_ld_idx  = (r_state == ST_WAIT) ? r_idx : w_idx;
  assign w_ld_wr   = (r_state == ST_WAIT) ? r_write : hwrite;
  assign w_commit  = (r_state == ST_RESP) && r_write;
  assign w_rd_load = (w_next == ST_RESP) && !w_ld_wr;
  assign w_rd_val  = (w_commit && (r_idx == w_ld_idx)) ?
                     hwdata : r_mem[w_ld_idx];

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_hrdata <= 32'd0;
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_idx;
        r_write <= hwrite;
      end
      if (w_commit)  r_mem[r_idx] <= hwdata;
      if (w_rd_load) r_hrdata     <= w_rd_val;
    end
  end

  assign hready = w_ready;
  assign hresp  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ?
                  2'b01 : 2'b00;
  assign hrdata = r_hrdata;

endmodule
